// File: rtl/lift_shaft_if.sv
// Motion/sensing interface between the lift controller (master) and the shaft plant model (slave).
// The controller drives the i_* commands. The shaft drives the o_* sense and status signals.
interface lift_shaft_if #(
  parameter int N_FLOORS = 12
);
  localparam int FLOOR_W = $clog2(N_FLOORS);

  logic                i_motion;
  logic                i_direction;
  logic                i_door_open;
  logic [N_FLOORS-1:0] o_floor_sense;
  logic [FLOOR_W-1:0]  o_floor_idx;
  logic                o_at_floor;
  logic                o_moving;
  logic                o_overtravel;
  logic                o_door_fault;

  modport master (
    output i_motion, i_direction, i_door_open,
    input  o_floor_sense, o_floor_idx, o_at_floor, o_moving, o_overtravel, o_door_fault
  );

  modport slave (
    input  i_motion, i_direction, i_door_open,
    output o_floor_sense, o_floor_idx, o_at_floor, o_moving, o_overtravel, o_door_fault
  );
endinterface

// File: rtl/lift_shaft_model.sv
// Synthesizable plant model of a lift car in its shaft.
// It turns motion commands into a one-hot floor sense vector, with finite travel time between floors.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ALIGNED  | car level with floor_q, waiting for a motion command
// MOVE_UP  | travelling floor_q -> floor_q+1, cnt_q counts cycles of the hop
// MOVE_DN  | travelling floor_q -> floor_q-1, cnt_q counts cycles of the hop
module lift_shaft_model #(
  parameter int N_FLOORS      = 12,
  parameter int TRAVEL_CYCLES = 16,
  parameter int INIT_FLOOR    = 0
) (
  input  logic          clk,
  input  logic          reset,
  lift_shaft_if.slave   bus
);
  localparam int FW = $clog2(N_FLOORS);
  localparam int CW = $clog2(TRAVEL_CYCLES);

  localparam logic [FW-1:0] TOP       = FW'(N_FLOORS - 1);
  localparam logic [FW-1:0] INIT      = FW'(INIT_FLOOR);
  localparam logic [CW-1:0] CNT_LAST  = CW'(TRAVEL_CYCLES - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(TRAVEL_CYCLES / 2);

  typedef enum logic [1:0] {
    ALIGNED = 2'd0,
    MOVE_UP = 2'd1,
    MOVE_DN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [FW-1:0]   floor_q, floor_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            dir_q, dir_d;
  logic            overtravel_q, overtravel_d;
  logic            door_fault_q, door_fault_d;

  logic [FW-1:0]   next_floor;
  logic [FW-1:0]   end_floor;
  logic [FW-1:0]   floor_idx;
  logic            at_end_cmd;

  // While travelling, the destination follows the direction latched at departure.
  assign next_floor = dir_q ? floor_q + FW'(1) : floor_q - FW'(1);
  assign end_floor  = dir_q ? TOP : '0;
  assign at_end_cmd = (bus.i_direction && (floor_q == TOP)) ||
                      (!bus.i_direction && (floor_q == '0));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ALIGNED;
      floor_q      <= INIT;
      cnt_q        <= '0;
      dir_q        <= 1'b0;
      overtravel_q <= 1'b0;
      door_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      floor_q      <= floor_d;
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      overtravel_q <= overtravel_d;
      door_fault_q <= door_fault_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    floor_d      = floor_q;
    cnt_d        = cnt_q;
    dir_d        = dir_q;
    overtravel_d = 1'b0;
    door_fault_d = door_fault_q;

    case (state_q)
      ALIGNED: begin
        if (bus.i_motion) begin
          if (bus.i_door_open) door_fault_d = 1'b1;
          // An end-floor request flags overtravel even with the door open.
          if (at_end_cmd) begin
            overtravel_d = 1'b1;
          end else if (!bus.i_door_open) begin
            state_d = bus.i_direction ? MOVE_UP : MOVE_DN;
            cnt_d   = '0;
            dir_d   = bus.i_direction;
          end
        end
      end
      MOVE_UP, MOVE_DN: begin
        if (bus.i_door_open) door_fault_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          floor_d = next_floor;
          cnt_d   = '0;
          if (!bus.i_motion) begin
            state_d = ALIGNED;
          end else if (next_floor == end_floor) begin
            state_d      = ALIGNED;
            overtravel_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ALIGNED;
        cnt_d   = '0;
      end
    endcase
  end

  // The nearest floor switches over halfway through a hop.
  assign floor_idx = ((state_q != ALIGNED) && (cnt_q >= CNT_HALF)) ? next_floor : floor_q;

  assign bus.o_floor_idx   = floor_idx;
  assign bus.o_floor_sense = {{(N_FLOORS-1){1'b0}}, 1'b1} << floor_idx;
  assign bus.o_at_floor    = (state_q == ALIGNED);
  assign bus.o_moving      = (state_q != ALIGNED);
  assign bus.o_overtravel  = overtravel_q;
  assign bus.o_door_fault  = door_fault_q;
endmodule

// File: tb/tb_lift_shaft_model.sv
// Self-checking bench for lift_shaft_model.
// It uses a position-in-cycles reference model and combines directed scenarios with randomized command streams.
module tb_lift_shaft_model;
  localparam int N  = 12;
  localparam int T  = 16;
  localparam int FW = $clog2(N);
  localparam int VW = N + FW + 4;

  logic clk;
  logic reset;

  lift_shaft_if #(.N_FLOORS(N)) bus ();

  lift_shaft_model #(.N_FLOORS(N), .TRAVEL_CYCLES(T), .INIT_FLOOR(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: absolute car position measured in travel cycles.
  int pos;
  bit trav;
  bit mdir;
  bit exp_ovt;
  bit exp_fault;

  wire [VW-1:0] dut_vec = {bus.o_floor_sense, bus.o_floor_idx, bus.o_at_floor,
                           bus.o_moving, bus.o_overtravel, bus.o_door_fault};

  function automatic int model_nearest();
    if (!trav || mdir) return (pos + T/2) / T;
    return (pos + T/2 - 1) / T;
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [N-1:0] oh;
    int nf;
    nf = model_nearest();
    oh = '0;
    oh[nf] = 1'b1;
    return {oh, FW'(nf), trav ? 1'b0 : 1'b1, trav ? 1'b1 : 1'b0,
            exp_ovt ? 1'b1 : 1'b0, exp_fault ? 1'b1 : 1'b0};
  endfunction

  task automatic model_clear();
    pos = 0; trav = 0; mdir = 0; exp_ovt = 0; exp_fault = 0;
  endtask

  task automatic model_edge(input bit m, input bit d, input bit dr);
    int fl;
    exp_ovt = 0;
    if (!trav) begin
      if (m) begin
        fl = pos / T;
        if (dr) exp_fault = 1;
        if ((d && fl == N-1) || (!d && fl == 0)) exp_ovt = 1;
        else if (!dr) begin
          trav = 1;
          mdir = d;
        end
      end
    end else begin
      if (dr) exp_fault = 1;
      pos += mdir ? 1 : -1;
      if (pos % T == 0) begin
        fl = pos / T;
        if (!m) trav = 0;
        else if ((mdir && fl == N-1) || (!mdir && fl == 0)) begin
          trav = 0;
          exp_ovt = 1;
        end
      end
    end
  endtask

  task automatic step(input bit m, input bit d, input bit dr);
    bus.i_motion    = m;
    bus.i_direction = d;
    bus.i_door_open = dr;
    @(posedge clk);
    model_edge(m, d, dr);
    #1;
  endtask

  task automatic do_reset();
    bus.i_motion = 0; bus.i_direction = 0; bus.i_door_open = 0;
    reset = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 reset = 1;
  endtask

  task automatic goto_floor(input int target);
    int guard;
    for (int p = 0; p < 2*N && pos / T != target; p++) begin
      step(1, target > pos / T, 0);
      guard = 0;
      while (trav && guard < 2*T) begin
        step(0, 0, 0);
        guard++;
      end
    end
  endtask

  task automatic test_reset();
    bus.i_motion = 0; bus.i_direction = 0; bus.i_door_open = 0;
    reset = 0;
    model_clear();
    #7;
    checks++;
    if (dut_vec !== {12'h001, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", dut_vec, {12'h001, 4'd0, 4'b1000});
    end
    @(posedge clk);
    #1 reset = 1;
    for (int i = 0; i < 100; i++) begin
      step(0, $urandom_range(0, 1), 0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL idle_after_reset cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_single_trip();
    do_reset();
    step(1, 1, 0);
    checks++;
    if (bus.o_moving !== 1'b1 || bus.o_at_floor !== 1'b0) begin
      failures++;
      $display("FAIL trip_depart moving=%b at_floor=%b exp moving=1 at_floor=0", bus.o_moving, bus.o_at_floor);
    end
    for (int k = 1; k <= 18; k++) begin
      step(0, 0, 0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL trip_model k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
      end
      if (k == 7 || k == 8) begin
        checks++;
        if (bus.o_floor_sense !== ((k == 7) ? 12'h001 : 12'h002)) begin
          failures++;
          $display("FAIL trip_sense k=%0d got=%h exp=%h", k, bus.o_floor_sense, (k == 7) ? 12'h001 : 12'h002);
        end
      end
      if (k == 15 || k == 16) begin
        checks++;
        if (bus.o_at_floor !== (k == 16)) begin
          failures++;
          $display("FAIL trip_arrive k=%0d at_floor=%b exp=%b", k, bus.o_at_floor, k == 16);
        end
      end
    end
  endtask

  task automatic test_run_to_top();
    bit hold;
    bit reached;
    int pulses;
    do_reset();
    hold = 1; reached = 0; pulses = 0;
    for (int i = 0; i < (N-1)*T + 10; i++) begin
      step(hold, 1, 0);
      if (bus.o_overtravel === 1'b1) pulses++;
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL run_top_model cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
      if (!trav && pos == (N-1)*T) begin
        hold = 0;
        reached = 1;
      end
    end
    checks++;
    if (!reached || pulses != 1 || bus.o_floor_sense !== 12'h800) begin
      failures++;
      $display("FAIL run_top_end reached=%0d pulses=%0d sense=%h exp pulses=1 sense=800", reached, pulses, bus.o_floor_sense);
    end
  endtask

  task automatic test_overtravel_bottom();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0);
      checks++;
      if (bus.o_overtravel !== 1'b1 || bus.o_moving !== 1'b0 || bus.o_floor_sense !== 12'h001) begin
        failures++;
        $display("FAIL bottom_overtravel cyc=%0d ovt=%b moving=%b sense=%h exp 1 0 001", i,
                 bus.o_overtravel, bus.o_moving, bus.o_floor_sense);
      end
    end
    step(0, 0, 0);
    checks++;
    if (dut_vec !== exp_vec()) begin
      failures++;
      $display("FAIL bottom_release got=%h exp=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_door_fault();
    do_reset();
    goto_floor(3);
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 1);
      checks++;
      if (bus.o_door_fault !== 1'b1 || bus.o_moving !== 1'b0 || bus.o_floor_idx !== 4'd3) begin
        failures++;
        $display("FAIL door_no_depart cyc=%0d fault=%b moving=%b idx=%0d exp 1 0 3", i,
                 bus.o_door_fault, bus.o_moving, bus.o_floor_idx);
      end
    end
    for (int i = 0; i < 30; i++) begin
      step(i == 0, 0, 0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL door_sticky cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
    end
    do_reset();
    checks++;
    if (bus.o_door_fault !== 1'b0) begin
      failures++;
      $display("FAIL door_fault_clear got=%b exp=0", bus.o_door_fault);
    end
  endtask

  task automatic test_dir_flip_and_reset();
    do_reset();
    goto_floor(2);
    step(1, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL flip_model cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if (bus.o_floor_idx !== 4'd3 || bus.o_at_floor !== 1'b1) begin
      failures++;
      $display("FAIL flip_arrive idx=%0d at_floor=%b exp 3 1", bus.o_floor_idx, bus.o_at_floor);
    end
    step(1, 1, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0);
    #2 reset = 0;
    #1;
    checks++;
    if (bus.o_floor_sense !== 12'h001 || bus.o_moving !== 1'b0 || bus.o_floor_idx !== 4'd0) begin
      failures++;
      $display("FAIL midtrip_reset sense=%h moving=%b idx=%0d exp 001 0 0", bus.o_floor_sense,
               bus.o_moving, bus.o_floor_idx);
    end
    model_clear();
    @(posedge clk);
    #1 reset = 1;
  endtask

  task automatic test_random();
    bit m, d, dr;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if (i % 800 == 799) do_reset();
      m  = ($urandom_range(0, 3) != 0);
      d  = ($urandom_range(0, 9) < ((i / 400) % 2 == 0 ? 7 : 3));
      dr = ($urandom_range(0, 199) == 0);
      step(m, d, dr);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    reset = 0;
    bus.i_motion = 0; bus.i_direction = 0; bus.i_door_open = 0;
    model_clear();
    test_reset();
    test_single_trip();
    test_run_to_top();
    test_overtravel_bottom();
    test_door_fault();
    test_dir_flip_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
